// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_loader
// Brief   : Boot-time loader that packs a byte stream into 9-bit instructions
//           and writes them from address 0, holding the CPU until it is done.
// Revision: 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9,
   parameter int DEPTH   = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_byte,
   input  logic               in_last,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [ADDR_W:0]    load_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t             r_state;
   logic [7:0]         r_lo;
   logic               r_last;
   logic [ADDR_W:0]    r_count;
   logic               r_in_ready;
   logic               r_wr_en;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [INSTR_W-1:0] r_wr_data;
   logic               r_cpu_hold;
   logic               r_done;
   logic               r_error;

   logic               w_fire;
   logic               w_hi_bad;

   assign w_fire   = in_valid && r_in_ready;
   // High byte may only carry instruction bit 8; a full memory never wraps.
   assign w_hi_bad = (in_byte[7:1] != 7'd0) || (r_count == C_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_lo       <= 8'd0;
         r_last     <= 1'b0;
         r_count    <= '0;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_cpu_hold <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LO;
                  r_in_ready <= 1'b1;
                  r_error    <= 1'b0;
                  r_count    <= '0;
                  r_cpu_hold <= 1'b1;
               end
            end
            S_LO: begin
               if (w_fire) begin
                  r_lo <= in_byte;
                  if (in_last) begin
                     r_error    <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_state <= S_HI;
                  end
               end
            end
            S_HI: begin
               if (w_fire) begin
                  r_last     <= in_last;
                  r_in_ready <= 1'b0;
                  if (w_hi_bad) begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_count[ADDR_W-1:0];
                     r_wr_data <= {in_byte[0], r_lo};
                     r_state   <= S_WR;
                  end
               end
            end
            S_WR: begin
               r_count <= r_count + C_ONE;
               if (r_last) begin
                  r_done     <= 1'b1;
                  r_cpu_hold <= 1'b0;
                  r_state    <= S_DONE;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_LO;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_in_ready <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cpu_hold   = r_cpu_hold;
   assign done       = r_done;
   assign error      = r_error;
   assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_loader
// Brief   : Directed, table-driven bench for the instruction memory loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 9;
   localparam int DEPTH   = 256;

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b0;
   logic               start    = 1'b0;
   logic               in_valid = 1'b0;
   logic [7:0]         in_byte  = 8'd0;
   logic               in_last  = 1'b0;
   logic               in_ready;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [INSTR_W-1:0] wr_data;
   logic               cpu_hold;
   logic               done;
   logic               error;
   logic [ADDR_W:0]    load_count;

   instr_mem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .in_last    (in_last),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_total  = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   int wq_addr[$];
   int wq_data[$];

   always @(negedge clk) begin
      if (wr_en) begin
         wq_addr.push_back(int'(wr_addr));
         wq_data.push_back(int'(wr_data));
         wr_cnt++;
      end
      if (done) done_cnt++;
   end

   typedef struct {
      logic       first;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       last;
      int         gap;
      int         exp_addr;
      int         exp_data;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_total++;
      if (act === 32'(exp)) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n;
      in_valid = 1'b1;
      in_byte  = b;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL handshake: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_wr;
      int base_done;
      int errs;
      logic [7:0] wb;

      vecs[0] = '{1'b1, 8'h34, 8'h01, 1'b1, 0, 0, 'h134};
      vecs[1] = '{1'b1, 8'hAA, 8'h00, 1'b0, 2, 0, 'h0AA};
      vecs[2] = '{1'b0, 8'h55, 8'h01, 1'b0, 0, 1, 'h155};
      vecs[3] = '{1'b0, 8'hFF, 8'h01, 1'b1, 3, 2, 'h1FF};

      // reset state
      idle(2);
      chk("rst cpu_hold", cpu_hold, 1);
      chk("rst in_ready", in_ready, 0);
      chk("rst wr_en", wr_en, 0);
      chk("rst wr_addr", wr_addr, 0);
      chk("rst wr_data", wr_data, 0);
      chk("rst done", done, 0);
      chk("rst error", error, 0);
      chk("rst load_count", load_count, 0);
      rst_n = 1'b1;
      idle(1);

      // single-word load then a three-word load with gaps and stalls
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].first) begin
            pulse_start();
            chk("start cpu_hold", cpu_hold, 1);
            chk("start in_ready", in_ready, 1);
         end
         idle(vecs[i].gap);
         send_byte(vecs[i].lo, 1'b0);
         idle(vecs[i].gap);
         send_byte(vecs[i].hi, vecs[i].last);
         chk("vec wr_en", wr_en, 1);
         chk("vec wr_addr", wr_addr, vecs[i].exp_addr);
         chk("vec wr_data", wr_data, vecs[i].exp_data);
         idle(1);
         chk("vec wr_en one cycle", wr_en, 0);
         if (vecs[i].last) begin
            chk("vec done", done, 1);
            chk("vec cpu_hold released", cpu_hold, 0);
            idle(1);
            chk("vec done one cycle", done, 0);
            chk("vec load_count", load_count, vecs[i].exp_addr + 1);
            chk("vec error", error, 0);
         end else begin
            chk("vec ready for next lo", in_ready, 1);
         end
      end

      // odd byte count
      base_wr   = wr_cnt;
      base_done = done_cnt;
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h00, 1'b0);
      idle(1);
      send_byte(8'h11, 1'b1);
      chk("odd error", error, 1);
      chk("odd cpu_hold", cpu_hold, 1);
      chk("odd in_ready", in_ready, 0);
      idle(2);
      chk("odd write count", wr_cnt - base_wr, 1);
      chk("odd no done", done_cnt - base_done, 0);
      pulse_start();
      chk("start clears error", error, 0);

      // bad high byte
      base_wr = wr_cnt;
      send_byte(8'h12, 1'b0);
      send_byte(8'h03, 1'b0);
      chk("badhi error", error, 1);
      chk("badhi wr_en", wr_en, 0);
      idle(2);
      chk("badhi no write", wr_cnt - base_wr, 0);
      chk("badhi load_count", load_count, 0);

      // fill all 256 words, then one more
      pulse_start();
      wq_addr.delete();
      wq_data.delete();
      base_wr = wr_cnt;
      for (int w = 0; w < DEPTH; w++) begin
         wb = 8'(w);
         send_byte(wb, 1'b0);
         send_byte({7'd0, wb[0]}, 1'b0);
      end
      send_byte(8'hAB, 1'b0);
      send_byte(8'h01, 1'b0);
      chk("full error", error, 1);
      chk("full wr_en", wr_en, 0);
      idle(2);
      chk("full write count", wr_cnt - base_wr, DEPTH);
      chk("full last addr", wq_addr[DEPTH-1], DEPTH - 1);
      chk("full last data", wq_data[DEPTH-1], 'h1FF);
      errs = 0;
      for (int k = 0; k < wq_addr.size(); k++) begin
         if (wq_addr[k] != k || wq_data[k] != (((k & 1) << 8) | (k & 'hFF))) errs++;
      end
      chk("full sequence", errs, 0);
      chk("full load_count", load_count, DEPTH);
      chk("full cpu_hold", cpu_hold, 1);

      // async reset in HI, then while a write strobe is up
      pulse_start();
      send_byte(8'h22, 1'b0);
      chk("pre-reset in_ready", in_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async in_ready", in_ready, 0);
      chk("async cpu_hold", cpu_hold, 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      pulse_start();
      send_byte(8'h22, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("pre-reset wr_en", wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async wr_en", wr_en, 0);
      chk("async wr_addr", wr_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      pulse_start();
      send_byte(8'h77, 1'b0);
      send_byte(8'h00, 1'b1);
      chk("reload wr_en", wr_en, 1);
      chk("reload wr_addr", wr_addr, 0);
      chk("reload wr_data", wr_data, 'h077);
      idle(1);
      chk("reload done", done, 1);
      idle(1);

      // start during a load is ignored; reload after success
      pulse_start();
      send_byte(8'h10, 1'b0);
      pulse_start();
      send_byte(8'h01, 1'b0);
      chk("ign wr_addr", wr_addr, 0);
      chk("ign wr_data", wr_data, 'h110);
      idle(1);
      pulse_start();
      send_byte(8'h20, 1'b0);
      send_byte(8'h00, 1'b1);
      chk("ign wr_addr 2", wr_addr, 1);
      chk("ign wr_data 2", wr_data, 'h020);
      idle(1);
      chk("ign done", done, 1);
      idle(1);
      chk("ign error", error, 0);
      chk("ign load_count", load_count, 2);
      chk("idle cpu_hold low", cpu_hold, 0);
      pulse_start();
      chk("reload cpu_hold rises", cpu_hold, 1);
      send_byte(8'h05, 1'b0);
      send_byte(8'h01, 1'b1);
      chk("reload2 wr_data", wr_data, 'h105);
      idle(1);
      chk("reload2 done", done, 1);
      chk("reload2 cpu_hold falls", cpu_hold, 0);
      chk("reload2 load_count", load_count, 1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
